// File: rtl/irq_pkg.sv
// irq_pkg: shared types and register map for the interrupt controller
package irq_pkg;
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} irq_state_t;
    localparam logic [4:0] OFF_PEND  = 5'h00;
    localparam logic [4:0] OFF_MASK  = 5'h04;
    localparam logic [4:0] OFF_CTRL  = 5'h08;
    localparam logic [4:0] OFF_CAUSE = 5'h0C;
    localparam logic [4:0] OFF_EOI   = 5'h10;
    localparam int CAUSE_VALID_BIT = 31;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: lowest-index-wins priority encoder
module irq_prio_enc #(
    parameter int NSRC = 4
) (
    input  logic [NSRC-1:0] req_i,
    output logic [3:0]      idx_o,
    output logic            vld_o
);
    always_comb begin
        idx_o = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (req_i[i]) idx_o = 4'(i);
    end
    assign vld_o = |req_i;
endmodule

// File: rtl/irq_controller.sv
// irq_controller: edge-latched, masked interrupt controller with
// request/service/EOI handshake for the single-cycle core
module irq_controller
    import irq_pkg::*;
#(
    parameter int          NSRC = 4,
    parameter logic [31:0] BASE = 32'h40000030
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ker,
    input  logic [NSRC-1:0] src,
    input  logic            rd,
    input  logic            wr,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            irqout
);
    irq_state_t      state_q;
    logic [NSRC-1:0] src_q, pend_q, pend_d, mask_q, active;
    logic            live_q, gie_q, cause_vld_q, irq_q, win_vld;
    logic [3:0]      cause_idx_q, win_idx;
    logic [31:0]     off, cause;
    logic            hit, sel_pend, sel_mask, sel_ctrl, sel_cause, sel_eoi, eoi_clr;
    logic            unused_ok;

    assign off       = {addr[31:2], 2'b00} - BASE;
    assign hit       = off < 32'h14;
    assign sel_pend  = hit && off[4:0] == OFF_PEND;
    assign sel_mask  = hit && off[4:0] == OFF_MASK;
    assign sel_ctrl  = hit && off[4:0] == OFF_CTRL;
    assign sel_cause = hit && off[4:0] == OFF_CAUSE;
    assign sel_eoi   = hit && off[4:0] == OFF_EOI;
    assign unused_ok = ^{addr[1:0], wdata};

    assign cause = 32'(cause_idx_q) | (32'(cause_vld_q) << CAUSE_VALID_BIT);
    assign rdata = !rd      ? '0 :
                   sel_pend  ? 32'(pend_q) :
                   sel_mask  ? 32'(mask_q) :
                   sel_ctrl  ? {31'b0, gie_q} :
                   sel_cause ? cause : '0;

    assign active  = pend_q & mask_q;
    assign eoi_clr = wr && sel_eoi && state_q == SERVICE;
    assign irqout  = irq_q && !ker;

    irq_prio_enc #(.NSRC(NSRC)) u_prio (
        .req_i (active),
        .idx_o (win_idx),
        .vld_o (win_vld)
    );

    // New edges are OR-ed in last so a same-edge set beats W1C or EOI clear;
    // live_q swallows the first cycle so a level held through reset is not an edge.
    always_comb begin
        pend_d = pend_q;
        if (wr && sel_pend) pend_d = pend_d & ~wdata[NSRC-1:0];
        if (eoi_clr) pend_d = pend_d & ~(NSRC'(1) << cause_idx_q);
        pend_d = pend_d | (src & ~src_q & {NSRC{live_q}});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            src_q       <= '0;
            pend_q      <= '0;
            mask_q      <= '0;
            live_q      <= 1'b0;
            gie_q       <= 1'b0;
            cause_vld_q <= 1'b0;
            cause_idx_q <= '0;
            irq_q       <= 1'b0;
        end else begin
            src_q  <= src;
            live_q <= 1'b1;
            pend_q <= pend_d;
            if (wr && sel_mask) mask_q <= wdata[NSRC-1:0];
            if (wr && sel_ctrl) gie_q <= wdata[0];
            unique case (state_q)
                IDLE: begin
                    if (gie_q && win_vld && !ker) begin
                        state_q <= REQ;
                        irq_q   <= 1'b1;
                    end
                end
                REQ: begin
                    if (!gie_q || !win_vld) begin
                        state_q <= IDLE;
                        irq_q   <= 1'b0;
                    end else if (ker) begin
                        state_q     <= SERVICE;
                        irq_q       <= 1'b0;
                        cause_idx_q <= win_idx;
                        cause_vld_q <= 1'b1;
                    end
                end
                SERVICE: begin
                    if (eoi_clr) begin
                        state_q     <= IDLE;
                        cause_vld_q <= 1'b0;
                    end else if (!ker) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    irq_q   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed vectors with hand-computed expectations
module tb_irq_controller;
    localparam logic [31:0] A_PEND  = 32'h40000030;
    localparam logic [31:0] A_MASK  = 32'h40000034;
    localparam logic [31:0] A_CTRL  = 32'h40000038;
    localparam logic [31:0] A_CAUSE = 32'h4000003C;
    localparam logic [31:0] A_EOI   = 32'h40000040;

    logic        clk = 1'b0, reset, ker, rd, wr, irqout;
    logic [3:0]  src;
    logic [31:0] addr, wdata, rdata;
    int          n_chk = 0, n_pass = 0;

    irq_controller #(.NSRC(4), .BASE(32'h40000030)) dut (
        .clk(clk), .reset(reset), .ker(ker), .src(src), .rd(rd), .wr(wr),
        .addr(addr), .wdata(wdata), .rdata(rdata), .irqout(irqout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wr = 1'b1;
        tick();
        wr = 1'b0;
    endtask

    task automatic bus_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a; rd = 1'b1;
        #1;
        chk(tag, rdata, exp);
        rd = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ker = 1'b0; rd = 1'b0; wr = 1'b0;
        addr = '0; wdata = '0; src = 4'b0100;
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();
        bus_rd("rst_pend", A_PEND, 32'h0);
        bus_rd("rst_mask", A_MASK, 32'h0);
        bus_rd("rst_ctrl", A_CTRL, 32'h0);
        bus_rd("rst_cause", A_CAUSE, 32'h0);
        bus_rd("rst_eoi", A_EOI, 32'h0);
        chk("rst_irq", 32'(irqout), 32'h0);
        src = 4'b0000;
        tick();
        bus_rd("src_fall_pend", A_PEND, 32'h0);

        src = 4'b0001;
        bus_wr(A_PEND, 32'hFFFF_FFFF);
        src = 4'b0000;
        bus_rd("set_wins", A_PEND, 32'h1);
        bus_wr(A_EOI, 32'h1);
        bus_rd("eoi_idle_ignored", A_PEND, 32'h1);
        bus_wr(A_PEND, 32'h1);
        bus_rd("w1c", A_PEND, 32'h0);

        bus_wr(A_MASK, 32'hF);
        bus_wr(A_CTRL, 32'h1);
        bus_rd("mask_rd", A_MASK, 32'hF);
        bus_rd("ctrl_rd", A_CTRL, 32'h1);
        bus_rd("unmapped", 32'h40000044, 32'h0);
        src = 4'b0010;
        tick();
        src = 4'b0000;
        bus_rd("p1_pend", A_PEND, 32'h2);
        chk("p1_irq_lat", 32'(irqout), 32'h0);
        tick();
        chk("p1_irq", 32'(irqout), 32'h1);
        ker = 1'b1;
        #1;
        chk("p1_ker_gate", 32'(irqout), 32'h0);
        tick();
        chk("p1_svc_irq", 32'(irqout), 32'h0);
        bus_rd("p1_cause", A_CAUSE, 32'h8000_0001);
        bus_wr(A_EOI, 32'h0);
        bus_rd("p1_eoi_pend", A_PEND, 32'h0);
        bus_rd("p1_eoi_cause", A_CAUSE, 32'h1);
        ker = 1'b0;
        tick();
        chk("p1_idle_irq", 32'(irqout), 32'h0);

        src = 4'b1001;
        tick();
        src = 4'b0000;
        tick();
        chk("p2_irq", 32'(irqout), 32'h1);
        ker = 1'b1;
        tick();
        bus_rd("p2_cause0", A_CAUSE, 32'h8000_0000);
        bus_wr(A_EOI, 32'h0);
        bus_rd("p2_pend8", A_PEND, 32'h8);
        ker = 1'b0;
        tick();
        chk("p2_irq_again", 32'(irqout), 32'h1);
        ker = 1'b1;
        tick();
        bus_rd("p2_cause3", A_CAUSE, 32'h8000_0003);
        bus_wr(A_EOI, 32'h0);
        bus_rd("p2_pend0", A_PEND, 32'h0);
        ker = 1'b0;

        bus_wr(A_MASK, 32'h1);
        src = 4'b0100;
        tick();
        src = 4'b0000;
        bus_rd("p3_pend", A_PEND, 32'h4);
        tick();
        chk("p3_masked", 32'(irqout), 32'h0);
        bus_wr(A_MASK, 32'h4);
        tick();
        chk("p3_unmasked", 32'(irqout), 32'h1);
        bus_wr(A_PEND, 32'h4);
        bus_rd("p3_w1c", A_PEND, 32'h0);
        tick();
        chk("p3_withdrawn", 32'(irqout), 32'h0);

        bus_wr(A_MASK, 32'hF);
        src = 4'b0010;
        tick();
        src = 4'b0000;
        tick();
        ker = 1'b1;
        tick();
        ker = 1'b0;
        tick();
        chk("p4_ker_drop_irq", 32'(irqout), 32'h0);
        bus_rd("p4_pend_kept", A_PEND, 32'h2);
        tick();
        chk("p4_rerequest", 32'(irqout), 32'h1);

        ker = 1'b1;
        tick();
        bus_rd("p5_cause", A_CAUSE, 32'h8000_0001);
        src = 4'b0010;
        bus_wr(A_EOI, 32'h0);
        src = 4'b0000;
        bus_rd("p5_pend_set_wins", A_PEND, 32'h2);
        bus_rd("p5_cause_clr", A_CAUSE, 32'h1);
        ker = 1'b0;
        tick();
        ker = 1'b1;
        tick();
        bus_rd("p5_svc_again", A_CAUSE, 32'h8000_0001);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus_rd("mid_rst_pend", A_PEND, 32'h0);
        bus_rd("mid_rst_mask", A_MASK, 32'h0);
        bus_rd("mid_rst_ctrl", A_CTRL, 32'h0);
        bus_rd("mid_rst_cause", A_CAUSE, 32'h0);
        ker = 1'b0;
        #1;
        chk("mid_rst_irq", 32'(irqout), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/irq_controller.md
# irq_controller

Memory-mapped interrupt controller for the single-cycle MIPS core. It latches rising edges from up to `NSRC` peripheral interrupt sources into pending bits and applies a mask and a global enable. It drives the CPU's `irqout`/IRQ line only while the core runs in user mode (`ker`=0), and it tracks the handler through a request/service/end-of-interrupt sequence. It sits on the peripheral bus next to the other address-bit-30 devices, and its read path is combinational to match the core's single-cycle load.

## Interface
- `NSRC`, 4: number of interrupt sources, 1..16.
- `BASE`, 32'h40000030: byte address of the register block. Five word registers, `BASE`..`BASE`+0x10.

- `clk` input 1: core clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `ker` input 1: kernel-mode flag (PC[31]); 1 = handler/kernel executing.
- `src` input NSRC: raw interrupt levels from peripherals, synchronous to `clk`.
- `rd` input 1: bus read strobe.
- `wr` input 1: bus write strobe.
- `addr` input 32: byte address from the ALU.
- `wdata` input 32: store data.
- `rdata` output 32: read data, combinational.
- `irqout` output 1: interrupt request to the control unit; registered.

## Operation
- Registers, word-aligned; `addr[1:0]` is ignored.
  - PEND, +0x0: pending bits [NSRC-1:0]. Read returns them. Write-1-to-clear.
  - MASK, +0x4: read/write enable per source.
  - CTRL, +0x8: bit0 = global enable (GIE). Read/write.
  - CAUSE, +0xC: read-only. Bit31 = the CAUSE latch is valid; [3:0] = latched source index.
  - EOI, +0x10: write-only; any write ends service.
- `rdata` = selected register when `rd` is high and `addr` matches; otherwise 0. Unused upper bits read 0.
- Edge detect: `src_q` <= `src` each cycle. A source's pending bit is set when `src & ~src_q`.
- Active set = PEND & MASK. The winner is the lowest active index (fixed priority).
- FSM `irq_state_t`:
  - IDLE → REQ when GIE && |active && !ker.
  - REQ → SERVICE when `ker`=1. The winner index is latched into CAUSE and CAUSE.valid is set.
  - REQ → IDLE when active becomes empty or GIE is cleared; the request is withdrawn.
  - SERVICE → IDLE on an EOI write. The latched source's PEND bit and CAUSE.valid are cleared in the same edge.
  - SERVICE → IDLE when `ker` falls without an EOI. PEND is untouched, so the source re-requests.
- `irqout` is 1 only in REQ and only while `ker`=0. It is registered from next-state, so it is 0 in the same cycle `ker` rises.

## Timing
- Reset: PEND=0, MASK=0, CTRL=0, CAUSE=0, `src_q`=0, state=IDLE, `irqout`=0. A `src` that is already high at reset release does not count as an edge until it goes low then high.
- Latency from `src` rising at edge n-1 to `irqout`=1:
  - PEND set at edge n.
  - `irqout`=1 after edge n+1, provided MASK, GIE and `ker`=0 hold.
- Writes take effect at the edge where `wr` is high. Reads reflect the state before that edge.
- Same-cycle set and clear:
  - Edge set and W1C clear on the same bit: set wins.
  - EOI in the same cycle as a new edge on the serviced source: PEND stays 1 and CAUSE.valid clears.
- MASK or GIE cleared while in SERVICE: no effect until EOI.
- EOI write while in IDLE or REQ: ignored, no PEND change.
- `reset` asserted mid-service: everything returns to reset values the next edge, and any in-flight request is dropped.
- Source indices ≥ NSRC are nonexistent. Their W1C bits are ignored.

## Structure
- Shared package `irq_pkg`:
  - `irq_state_t` (IDLE, REQ, SERVICE).
  - Register offsets OFF_PEND/OFF_MASK/OFF_CTRL/OFF_CAUSE/OFF_EOI.
  - CAUSE_VALID_BIT = 31.
- Sub-module `irq_prio_enc`: combinational lowest-index priority encoder, NSRC in, producing index[3:0] and valid.
- Everything else is in `irq_controller`. Expected size is about 200 lines.

## Test plan
- Reset, then read all registers → 0; `irqout`=0. Hold `src[2]` high across reset → PEND stays 0.
- MASK=0xF, CTRL=1, pulse `src[1]` one cycle → PEND=0x2 after one edge, then `irqout`=1. Raise `ker` → `irqout`=0 and CAUSE=0x80000001. Write EOI → PEND=0, state IDLE.
- Pulse `src[3]` and `src[0]` in the same cycle → CAUSE index 0. After EOI, `irqout` re-asserts once `ker`=0 and CAUSE index becomes 3.
- MASK=0x1, pulse `src[2]` → PEND=0x4 and `irqout` stays 0. Write MASK=0x4 → `irqout`=1 after one edge. Write PEND=0x4 while in REQ → REQ→IDLE and `irqout`=0.
- In SERVICE for source 1, drop `ker` with no EOI → IDLE, PEND still 0x2, and `irqout` re-asserts.
- In SERVICE for source 1, write EOI in the same cycle as a new `src[1]` edge → PEND=0x2 and CAUSE.valid=0. Assert `reset` mid-SERVICE → all registers 0 next edge.
